fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO; successor of the fixed 12-bit FIFO.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem_dp.sv | 35 +++
 rtl/fifo_sync_param.sv | 135 +++++++++++++
 tb/tb_fifo_sync_param.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions.
//  FIFO_REG / FIFO_FWFT : read-port mode constants for the SHOW_AHEAD parameter.
//  fifo_depth()         : number of words held by a FIFO with a given pointer width.
package fifo_pkg;

  localparam int unsigned FIFO_REG  = 0;  // registered read, data one cycle after pop
  localparam int unsigned FIFO_FWFT = 1;  // show-ahead, head word visible while not empty

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// 1-write/1-read register array: synchronous write, asynchronous read. Not reset.
// Ports:
//  clk_i    in   1          write clock
//  we_i     in   1          write enable
//  waddr_i  in   ADDR_SIZE  write address
//  wdata_i  in   DATA_SIZE  write data
//  raddr_i  in   ADDR_SIZE  read address
//  rdata_o  out  DATA_SIZE  read data (combinational from raddr_i)
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 12,
  parameter int unsigned ADDR_SIZE = 3
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int unsigned Depth = fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, runtime almost-full/almost-empty
// thresholds, sticky overflow/underflow error and registered or show-ahead read port.
// Ports:
//  clk                    in   1            clock, rising edge
//  reset_L                in   1            asynchronous active-low reset
//  write                  in   1            write request
//  data_in                in   DATA_SIZE    write data
//  read                   in   1            read/pop request
//  err_clr                in   1            clears sticky fifo_error
//  th_fifos_almost_full   in   ADDR_SIZE+1  almost_full threshold (words)
//  th_fifos_almost_empty  in   ADDR_SIZE+1  almost_empty threshold (words)
//  fifo_data_out          out  DATA_SIZE    read data
//  fifo_count             out  ADDR_SIZE+1  occupancy 0..2**ADDR_SIZE
//  fifo_empty             out  1            count == 0
//  fifo_full              out  1            count == depth
//  almost_empty           out  1            count <= almost-empty threshold
//  almost_full            out  1            count >= almost-full threshold
//  fifo_error             out  1            sticky overflow/underflow flag
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 12,
  parameter int unsigned ADDR_SIZE  = 3,
  parameter int unsigned SHOW_AHEAD = FIFO_REG
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 read,
  input  logic                 err_clr,
  input  logic [ADDR_SIZE:0]   th_fifos_almost_full,
  input  logic [ADDR_SIZE:0]   th_fifos_almost_empty,
  output logic [DATA_SIZE-1:0] fifo_data_out,
  output logic [ADDR_SIZE:0]   fifo_count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 fifo_error
);

  // Count value when every slot is occupied (2**ADDR_SIZE).
  localparam logic [ADDR_SIZE:0] FullCount = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 error_q, error_d;

  logic                 wr_ok;
  logic                 rd_ok;
  logic                 err_set;
  logic [DATA_SIZE-1:0] mem_rdata;

  // Flags are derived from the count register only, never from pointer comparison.
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FullCount);
  assign almost_empty = (count_q <= th_fifos_almost_empty);
  assign almost_full  = (count_q >= th_fifos_almost_full);
  assign fifo_count   = count_q;
  assign fifo_error   = error_q;

  // A write into a full FIFO is still taken when a pop frees the head slot in the same cycle.
  assign wr_ok   = write & (~fifo_full | read);
  assign rd_ok   = read & ~fifo_empty;
  assign err_set = (write & fifo_full & ~read) | (read & fifo_empty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    error_d  = error_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
      data_d   = mem_rdata;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_SIZE + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_SIZE + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as err_clr keeps the flag set.
    if (err_set) begin
      error_d = 1'b1;
    end else if (err_clr) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      error_q  <= error_d;
    end
  end

  fifo_mem_dp #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Show-ahead presents the head word directly; while empty it shows the last popped word
  // (zero after reset) rather than stale array contents.
  if (SHOW_AHEAD == FIFO_FWFT) begin : g_fwft
    assign fifo_data_out = fifo_empty ? data_q : mem_rdata;
  end else begin : g_reg
    assign fifo_data_out = data_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int unsigned Dw    = 12;
  localparam int unsigned Aw    = 3;
  localparam int unsigned Depth = 8;
  localparam int unsigned ThFull  = 6;
  localparam int unsigned ThEmpty = 1;

  logic          clk;
  logic          reset_L;
  logic          write;
  logic [Dw-1:0] data_in;
  logic          read;
  logic          err_clr;
  logic [Aw:0]   th_full;
  logic [Aw:0]   th_empty;

  logic [Dw-1:0] r_dout, f_dout;
  logic [Aw:0]   r_count, f_count;
  logic          r_empty, f_empty, r_full, f_full;
  logic          r_aempty, f_aempty, r_afull, f_afull;
  logic          r_err, f_err;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a queue plus the sticky flag and last popped word.
  logic [Dw-1:0] model_q[$];
  logic          m_err;
  logic [Dw-1:0] m_dout;

  fifo_sync_param #(.DATA_SIZE(Dw), .ADDR_SIZE(Aw), .SHOW_AHEAD(0)) u_reg (
    .clk(clk), .reset_L(reset_L), .write(write), .data_in(data_in), .read(read),
    .err_clr(err_clr), .th_fifos_almost_full(th_full), .th_fifos_almost_empty(th_empty),
    .fifo_data_out(r_dout), .fifo_count(r_count), .fifo_empty(r_empty), .fifo_full(r_full),
    .almost_empty(r_aempty), .almost_full(r_afull), .fifo_error(r_err)
  );

  fifo_sync_param #(.DATA_SIZE(Dw), .ADDR_SIZE(Aw), .SHOW_AHEAD(1)) u_fwft (
    .clk(clk), .reset_L(reset_L), .write(write), .data_in(data_in), .read(read),
    .err_clr(err_clr), .th_fifos_almost_full(th_full), .th_fifos_almost_empty(th_empty),
    .fifo_data_out(f_dout), .fifo_count(f_count), .fifo_empty(f_empty), .fifo_full(f_full),
    .almost_empty(f_aempty), .almost_full(f_afull), .fifo_error(f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check("reg.count", 32'(r_count), n);
    check("fwft.count", 32'(f_count), n);
    check("reg.empty", 32'(r_empty), 32'(n == 0));
    check("fwft.empty", 32'(f_empty), 32'(n == 0));
    check("reg.full", 32'(r_full), 32'(n == Depth));
    check("fwft.full", 32'(f_full), 32'(n == Depth));
    check("reg.almost_empty", 32'(r_aempty), 32'(n <= ThEmpty));
    check("fwft.almost_empty", 32'(f_aempty), 32'(n <= ThEmpty));
    check("reg.almost_full", 32'(r_afull), 32'(n >= ThFull));
    check("fwft.almost_full", 32'(f_afull), 32'(n >= ThFull));
    check("reg.error", 32'(r_err), 32'(m_err));
    check("fwft.error", 32'(f_err), 32'(m_err));
    check("reg.data_out", 32'(r_dout), 32'(m_dout));
    if (n != 0) check("fwft.data_out", 32'(f_dout), 32'(model_q[0]));
  endtask

  task automatic model_reset();
    model_q.delete();
    m_err  = 1'b0;
    m_dout = '0;
  endtask

  // Applies one clock edge of the FIFO rules to the queue model.
  task automatic model_step(input logic w, input logic [Dw-1:0] d, input logic r, input logic c);
    bit full, empty, wr_ok, rd_ok;
    full  = (model_q.size() == Depth);
    empty = (model_q.size() == 0);
    wr_ok = w && (!full || r);
    rd_ok = r && !empty;
    if ((w && full && !r) || (r && empty)) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    if (rd_ok) m_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
  endtask

  task automatic cycle(input logic w, input logic [Dw-1:0] d, input logic r, input logic c);
    write   = w;
    data_in = d;
    read    = r;
    err_clr = c;
    @(posedge clk);
    model_step(w, d, r, c);
    #1;
    check_all();
  endtask

  initial begin
    logic [Dw-1:0] seq;
    reset_L  = 1'b0;
    write    = 1'b0;
    data_in  = '0;
    read     = 1'b0;
    err_clr  = 1'b0;
    th_full  = 4'(ThFull);
    th_empty = 4'(ThEmpty);
    model_reset();

    // Reset held for two clocks.
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("fwft.reset_data_out", 32'(f_dout), 32'h0);
    reset_L = 1'b1;

    // Fill with 0x01A..0x08A, overflow once, then drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b1, Dw'(12'h01A + 12'h010 * i), 1'b0, 1'b0);
    cycle(1'b1, 12'h09A, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Underflow, clear, and error-beats-clear.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Simultaneous read+write while full.
    for (int i = 0; i < 8; i++) cycle(1'b1, Dw'(12'h100 + i), 1'b0, 1'b0);
    cycle(1'b1, 12'h0FF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous read+write while empty: write lands, read errors.
    cycle(1'b1, 12'h0AB, 1'b1, 1'b0);
    check("fwft.show_ahead_0AB", 32'(f_dout), 32'h0AB);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("reg.read_0AB", 32'(r_dout), 32'h0AB);

    // Steady-state streaming at count=3 across pointer wrap.
    seq = 12'h200;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, seq, 1'b0, 1'b0);
      seq++;
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, seq, 1'b1, 1'b0);
      seq++;
    end

    // Randomised traffic with occasional error clears.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), Dw'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : 1) &
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, Dw'($urandom), 1'b0, 1'b0);

    // Asynchronous reset mid-stream, sampled before the next clock edge.
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all();
    check("fwft.async_reset_data_out", 32'(f_dout), 32'h0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    cycle(1'b1, 12'h321, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
